// File: rtl/rv_decode_pkg.sv
// Shared opcode table, code-word bit positions and FSM state encoding
// for the fetch/decode front end that feeds fsm_alu.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Bit positions inside the one-hot code word understood by fsm_alu.
  localparam int CODE_LOAD     = 3;
  localparam int CODE_LOAD_FP  = 1;
  localparam int CODE_OP_IMM   = 11;
  localparam int CODE_AUIPC    = 5;
  localparam int CODE_STORE    = 8;
  localparam int CODE_STORE_FP = 9;
  localparam int CODE_OP       = 12;
  localparam int CODE_LUI      = 13;
  localparam int CODE_OP_FP    = 20;
  localparam int CODE_BRANCH   = 24;
  localparam int CODE_JALR     = 25;
  localparam int CODE_JAL      = 27;

  localparam int TMO_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } fdu_state_e;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus bundle between the fetch/decode unit, instruction memory and fsm_alu.
interface fetch_decode_unit_if #(
  parameter int XLEN = 64
) ();

  // imem: imem_req/imem_addr stay asserted and stable until a cycle with
  // imem_ready = 1, which is the single transfer cycle carrying imem_rdata.
  // exec: start pulses for one cycle; exec_done closes that instruction.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic [31:0]     ins;
  logic [31:0]     code;
  logic            start;
  logic            exec_done;

  modport master (
    output imem_req, imem_addr, ins, code, start,
    input  imem_ready, imem_rdata, exec_done
  );

  modport slave (
    input  imem_req, imem_addr, ins, code, start,
    output imem_ready, imem_rdata, exec_done
  );

endinterface

// File: rtl/opcode_classifier.sv
// Pure combinational map from a 7-bit major opcode to the fsm_alu one-hot
// class code; valid_o = 0 for any opcode outside the supported table.
module opcode_classifier
  import rv_decode_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output logic [31:0] code_o,
  output logic        valid_o
);

  always_comb begin
    code_o  = '0;
    valid_o = 1'b1;
    case (opcode_i)
      OPC_LOAD:     code_o[CODE_LOAD]     = 1'b1;
      OPC_LOAD_FP:  code_o[CODE_LOAD_FP]  = 1'b1;
      OPC_OP_IMM:   code_o[CODE_OP_IMM]   = 1'b1;
      OPC_AUIPC:    code_o[CODE_AUIPC]    = 1'b1;
      OPC_STORE:    code_o[CODE_STORE]    = 1'b1;
      OPC_STORE_FP: code_o[CODE_STORE_FP] = 1'b1;
      OPC_OP:       code_o[CODE_OP]       = 1'b1;
      OPC_LUI:      code_o[CODE_LUI]      = 1'b1;
      OPC_OP_FP:    code_o[CODE_OP_FP]    = 1'b1;
      OPC_BRANCH:   code_o[CODE_BRANCH]   = 1'b1;
      OPC_JALR:     code_o[CODE_JALR]     = 1'b1;
      OPC_JAL:      code_o[CODE_JAL]      = 1'b1;
      default:      valid_o               = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetches one instruction at pc, classifies it for fsm_alu, pulses start
// and waits for exec_done before the next fetch. Faults halt until reset.
module fetch_decode_unit
  import rv_decode_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [XLEN-1:0]      pc,
  fetch_decode_unit_if.master  bus,
  output logic                 illegal,
  output logic                 fetch_fault,
  output fdu_state_e           state_o
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(IMEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;

  fdu_state_e       state_q;
  logic [31:0]      ins_q;
  logic [31:0]      code_q;
  logic             start_q;
  logic             req_q;
  logic [XLEN-1:0]  addr_q;
  logic             ill_q;
  logic             ff_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;

  logic [31:0]      cls_code;
  logic             cls_valid;

  opcode_classifier u_classifier (
    .opcode_i (ins_q[6:0]),
    .code_o   (cls_code),
    .valid_o  (cls_valid)
  );

  assign tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ins_q   <= '0;
      code_q  <= '0;
      start_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ill_q   <= 1'b0;
      ff_q    <= 1'b0;
      tmo_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc;
            tmo_q   <= '0;
          end
        end
        FETCH: begin
          // A ready on the same cycle as the timeout still delivers the word.
          if (bus.imem_ready) begin
            ins_q   <= bus.imem_rdata;
            req_q   <= 1'b0;
            state_q <= DECODE;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TMO_LIMIT) begin
              ff_q    <= 1'b1;
              req_q   <= 1'b0;
              state_q <= HALT;
            end
          end
        end
        DECODE: begin
          if (cls_valid && (ins_q[1:0] == 2'b11)) begin
            code_q  <= cls_code;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end else begin
            code_q  <= '0;
            ill_q   <= 1'b1;
            state_q <= HALT;
          end
        end
        ISSUE: state_q <= EXEC;
        EXEC: begin
          if (bus.exec_done) begin
            if (run) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              addr_q  <= pc;
              tmo_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.ins       = ins_q;
  assign bus.code      = code_q;
  assign bus.start     = start_q;
  assign illegal       = ill_q;
  assign fetch_fault   = ff_q;
  assign state_o       = state_q;

endmodule
